// File: rtl/exu_ctl.sv
// exu_ctl: sequencing control for the IDU->EXU->LSU slot.
// Owns the i2e slot valid bit, the multi-cycle hold and the jump redirect.
//
// Ports:
//   i_sys_clk, i_sys_rst         clock, async active-high reset
//   i_idu_valid, i_idu_mc        IDU offer and multi-cycle flag
//   o_ctl_idu_ready              slot accepts the IDU instruction
//   o_ctl_i2e_load               load strobe for the external i2e register
//   o_ctl_i2e_valid              EXU result is final
//   i_e2l_ready                  LSU accepts the EXU result
//   i_exu_jmp_en, i_exu_jmp_pc   taken jump and target (used on retire)
//   o_ctl_flush                  kill IFU/IDU in-flight contents
//   o_ctl_redirect_en/_pc        PC redirect request to IFU
//   i_ifu_redirect_ack           IFU takes the redirect
//   o_ctl_busy                   controller is not in RUN
//   o_ctl_jmp_cnt                count of completed redirects
module exu_ctl #(
  parameter int ADDR_WIDTH = 32,
  parameter int MC_LAT     = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_idu_valid,
  input  logic                  i_idu_mc,
  output logic                  o_ctl_idu_ready,
  output logic                  o_ctl_i2e_load,
  output logic                  o_ctl_i2e_valid,
  input  logic                  i_e2l_ready,
  input  logic                  i_exu_jmp_en,
  input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
  output logic                  o_ctl_flush,
  output logic                  o_ctl_redirect_en,
  output logic [ADDR_WIDTH-1:0] o_ctl_redirect_pc,
  input  logic                  i_ifu_redirect_ack,
  output logic                  o_ctl_busy,
  output logic [CNT_WIDTH-1:0]  o_ctl_jmp_cnt
);

  localparam int MCW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam bit MC_EN = (MC_LAT > 1);
  localparam logic [MCW-1:0] MC_INIT =
    MCW'((MC_LAT > 1) ? (MC_LAT - 1) : 0);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULT  = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    slot_v;
  logic [MCW-1:0]          mc_cnt;
  logic [ADDR_WIDTH-1:0]   redirect_pc_q;
  logic [CNT_WIDTH-1:0]    jmp_cnt_q;

  logic i2e_valid;
  logic idu_ready;
  logic retire;
  logic jump;
  logic load;
  logic redir;

  // Target alignment drops the low pc bits.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^i_exu_jmp_pc[1:0];

  always_comb begin
    i2e_valid = 1'b0;
    redir     = 1'b0;
    unique case (state_q)
      RUN:     i2e_valid = slot_v;
      MULT:    i2e_valid = (mc_cnt == '0);
      REDIR:   redir     = 1'b1;
      default: ;
    endcase
    retire = i2e_valid && i_e2l_ready;
    jump   = retire && i_exu_jmp_en;
    // Only RUN refills; a jumping retire must not pull in a dead instr.
    idu_ready = (state_q == RUN) && (!slot_v || retire) && !jump;
    load      = i_idu_valid && idu_ready;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q       <= RUN;
      slot_v        <= 1'b0;
      mc_cnt        <= '0;
      redirect_pc_q <= '0;
      jmp_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (jump) begin
            slot_v        <= 1'b0;
            redirect_pc_q <= {i_exu_jmp_pc[ADDR_WIDTH-1:2], 2'b00};
            state_q       <= REDIR;
          end else if (load) begin
            slot_v <= 1'b1;
            if (i_idu_mc && MC_EN) begin
              mc_cnt  <= MC_INIT;
              state_q <= MULT;
            end
          end else if (retire) begin
            slot_v <= 1'b0;
          end
        end
        MULT: begin
          if (jump) begin
            slot_v        <= 1'b0;
            redirect_pc_q <= {i_exu_jmp_pc[ADDR_WIDTH-1:2], 2'b00};
            state_q       <= REDIR;
          end else if (retire) begin
            slot_v  <= 1'b0;
            state_q <= RUN;
          end else if (mc_cnt != '0) begin
            mc_cnt <= mc_cnt - 1'b1;
          end
        end
        REDIR: begin
          if (i_ifu_redirect_ack) begin
            jmp_cnt_q <= jmp_cnt_q + 1'b1;
            state_q   <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Reset forces every output low, even the ones idle RUN would raise.
  assign o_ctl_idu_ready   = idu_ready && !i_sys_rst;
  assign o_ctl_i2e_load    = load && !i_sys_rst;
  assign o_ctl_i2e_valid   = i2e_valid && !i_sys_rst;
  assign o_ctl_flush       = (redir || jump) && !i_sys_rst;
  assign o_ctl_redirect_en = redir && !i_sys_rst;
  assign o_ctl_redirect_pc =
    (redir && !i_sys_rst) ? redirect_pc_q : '0;
  assign o_ctl_busy        = (state_q != RUN) && !i_sys_rst;
  assign o_ctl_jmp_cnt     = jmp_cnt_q;

endmodule

// File: tb/tb_exu_ctl.sv
// tb_exu_ctl: directed bench for exu_ctl with a cycle-timestamp model.
// A narrow-counter second instance exercises the redirect counter wrap.
module tb_exu_ctl;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 0, imc = 0, er = 0, je = 0, ack = 0;
  logic [31:0] jpc = '0;

  logic        rdy, ld, vld, fl, ren, bsy;
  logic [31:0] rpc;
  logic [15:0] cnt;
  logic        w_rdy, w_ld, w_vld, w_fl, w_ren, w_bsy;
  logic [31:0] w_rpc;
  logic [3:0]  w_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          m_full, m_mc, m_redir;
  int          m_rdy;
  logic [31:0] m_pc;
  int          m_cnt;

  bit          e_rdy, e_ld, e_vld, e_fl, e_ren, e_bsy, e_ret, e_jmp;
  logic [31:0] e_rpc;

  exu_ctl #(.ADDR_WIDTH(32), .MC_LAT(MC), .CNT_WIDTH(16)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_idu_valid(iv), .i_idu_mc(imc),
    .o_ctl_idu_ready(rdy), .o_ctl_i2e_load(ld),
    .o_ctl_i2e_valid(vld), .i_e2l_ready(er),
    .i_exu_jmp_en(je), .i_exu_jmp_pc(jpc),
    .o_ctl_flush(fl), .o_ctl_redirect_en(ren),
    .o_ctl_redirect_pc(rpc), .i_ifu_redirect_ack(ack),
    .o_ctl_busy(bsy), .o_ctl_jmp_cnt(cnt)
  );

  exu_ctl #(.ADDR_WIDTH(32), .MC_LAT(MC), .CNT_WIDTH(4)) dut_w (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_idu_valid(iv), .i_idu_mc(imc),
    .o_ctl_idu_ready(w_rdy), .o_ctl_i2e_load(w_ld),
    .o_ctl_i2e_valid(w_vld), .i_e2l_ready(er),
    .i_exu_jmp_en(je), .i_exu_jmp_pc(jpc),
    .o_ctl_flush(w_fl), .o_ctl_redirect_en(w_ren),
    .o_ctl_redirect_pc(w_rpc), .i_ifu_redirect_ack(ack),
    .o_ctl_busy(w_bsy), .o_ctl_jmp_cnt(w_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h",
               name, cyc, act, exp);
    end
  endtask

  // Expected outputs from slot occupancy and result-ready timestamps.
  always @(negedge clk) begin
    e_rdy = 0; e_ld = 0; e_vld = 0; e_fl = 0;
    e_ren = 0; e_bsy = 0; e_ret = 0; e_jmp = 0;
    e_rpc = '0;
    if (rst) begin
      m_full = 0; m_mc = 0; m_redir = 0;
      m_pc = '0; m_cnt = 0;
    end else if (m_redir) begin
      e_fl = 1; e_ren = 1; e_bsy = 1; e_rpc = m_pc;
    end else begin
      e_vld = m_full && (cyc >= m_rdy);
      e_ret = e_vld && er;
      e_jmp = e_ret && je;
      e_rdy = !e_jmp && (!m_full || (e_ret && !m_mc));
      e_ld  = e_rdy && iv;
      e_fl  = e_jmp;
      e_bsy = m_full && m_mc;
    end
    chk("idu_ready", 32'(rdy), 32'(e_rdy));
    chk("i2e_load", 32'(ld), 32'(e_ld));
    chk("i2e_valid", 32'(vld), 32'(e_vld));
    chk("flush", 32'(fl), 32'(e_fl));
    chk("redirect_en", 32'(ren), 32'(e_ren));
    chk("redirect_pc", rpc, e_rpc);
    chk("busy", 32'(bsy), 32'(e_bsy));
    chk("jmp_cnt", 32'(cnt), 32'(m_cnt % 65536));
    chk("w_idu_ready", 32'(w_rdy), 32'(e_rdy));
    chk("w_i2e_load", 32'(w_ld), 32'(e_ld));
    chk("w_i2e_valid", 32'(w_vld), 32'(e_vld));
    chk("w_flush", 32'(w_fl), 32'(e_fl));
    chk("w_redirect_en", 32'(w_ren), 32'(e_ren));
    chk("w_redirect_pc", w_rpc, e_rpc);
    chk("w_busy", 32'(w_bsy), 32'(e_bsy));
    chk("w_jmp_cnt", 32'(w_cnt), 32'(m_cnt % 16));
  end

  always @(posedge clk) begin
    if (rst) begin
      m_full = 0; m_mc = 0; m_redir = 0;
      m_pc = '0; m_cnt = 0;
    end else if (m_redir) begin
      if (ack) begin
        m_cnt   = m_cnt + 1;
        m_redir = 0;
      end
    end else if (e_jmp) begin
      m_redir = 1;
      m_pc    = {jpc[31:2], 2'b00};
      m_full  = 0;
      m_mc    = 0;
    end else if (e_ld) begin
      m_full = 1;
      m_mc   = imc && (MC > 1);
      m_rdy  = cyc + (m_mc ? MC : 1);
    end else if (e_ret) begin
      m_full = 0;
      m_mc   = 0;
    end
    cyc++;
  end

  task automatic drive(bit v, bit mc, bit e, bit j,
                       logic [31:0] p, bit a);
    iv = v; imc = mc; er = e; je = j; jpc = p; ack = a;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  initial begin
    // reset
    drive(1, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("rst_idu_ready", 32'(rdy), 32'd0);
    chk("rst_load", 32'(ld), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    drive(0, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("post_rst_ready", 32'(rdy), 32'd1);
    chk("post_rst_cnt", 32'(cnt), 32'd0);
    tick;

    // T1 back-to-back single-cycle ops
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 0, 32'h0, 0);
      at_neg;
      chk("t1_load", 32'(ld), 32'd1);
      chk("t1_ready", 32'(rdy), 32'd1);
      chk("t1_valid", 32'(vld), (i > 0) ? 32'd1 : 32'd0);
      tick;
    end
    drive(0, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("t1_last_valid", 32'(vld), 32'd1);
    tick;
    at_neg;
    chk("t1_empty", 32'(vld), 32'd0);
    tick;

    // T2 multi-cycle op, IDU keeps offering
    drive(1, 1, 1, 0, 32'h0, 0);
    at_neg;
    chk("t2_load", 32'(ld), 32'd1);
    tick;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 1, 0, 32'h0, 0);
      at_neg;
      chk("t2_valid", 32'(vld), (i == 4) ? 32'd1 : 32'd0);
      chk("t2_ready", 32'(rdy), 32'd0);
      chk("t2_noload", 32'(ld), 32'd0);
      chk("t2_busy", 32'(bsy), 32'd1);
      tick;
    end
    drive(0, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("t2_idle_busy", 32'(bsy), 32'd0);
    chk("t2_idle_ready", 32'(rdy), 32'd1);
    tick;

    // T3 backpressure
    drive(1, 0, 0, 0, 32'h0, 0);
    at_neg;
    chk("t3_load", 32'(ld), 32'd1);
    tick;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 0, 32'h0, 0);
      at_neg;
      chk("t3_hold_valid", 32'(vld), 32'd1);
      chk("t3_hold_ready", 32'(rdy), 32'd0);
      chk("t3_hold_noload", 32'(ld), 32'd0);
      tick;
    end
    drive(1, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("t3_reopen_ready", 32'(rdy), 32'd1);
    chk("t3_reopen_load", 32'(ld), 32'd1);
    tick;
    drive(0, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("t3_next_valid", 32'(vld), 32'd1);
    tick;

    // T4 jump from RUN; stray jmp_en and ack before it are ignored
    drive(1, 0, 1, 1, 32'h0, 1);
    at_neg;
    chk("t4_stray_flush", 32'(fl), 32'd0);
    chk("t4_load", 32'(ld), 32'd1);
    tick;
    drive(1, 0, 1, 1, 32'h8000_0013, 0);
    at_neg;
    chk("t4_cnt0", 32'(cnt), 32'd0);
    chk("t4_flush", 32'(fl), 32'd1);
    chk("t4_noready", 32'(rdy), 32'd0);
    chk("t4_noload", 32'(ld), 32'd0);
    tick;
    drive(1, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("t4_ren", 32'(ren), 32'd1);
    chk("t4_pc", rpc, 32'h8000_0010);
    chk("t4_busy", 32'(bsy), 32'd1);
    tick;
    drive(0, 0, 1, 0, 32'h0, 1);
    at_neg;
    chk("t4_ren_ack", 32'(ren), 32'd1);
    tick;
    drive(0, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("t4_run_ren", 32'(ren), 32'd0);
    chk("t4_cnt1", 32'(cnt), 32'd1);
    tick;

    // jump retiring from MULT, ack in the first redirect cycle
    drive(1, 1, 1, 0, 32'h0, 0);
    tick;
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 1, 32'h1234_5677, 0);
      at_neg;
      chk("t4m_flush", 32'(fl), (i == 4) ? 32'd1 : 32'd0);
      tick;
    end
    drive(0, 0, 1, 0, 32'h0, 1);
    at_neg;
    chk("t4m_pc", rpc, 32'h1234_5674);
    tick;
    drive(0, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("t4m_cnt2", 32'(cnt), 32'd2);
    tick;

    // T5 reset mid-redirect
    drive(1, 0, 1, 0, 32'h0, 0);
    tick;
    drive(0, 0, 1, 1, 32'hA5A5_A5A7, 0);
    tick;
    drive(0, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("t5_ren", 32'(ren), 32'd1);
    tick;
    rst = 1'b1;
    #1;
    chk("t5_rst_ren", 32'(ren), 32'd0);
    chk("t5_rst_flush", 32'(fl), 32'd0);
    chk("t5_rst_busy", 32'(bsy), 32'd0);
    chk("t5_rst_cnt", 32'(cnt), 32'd0);
    chk("t5_rst_ready", 32'(rdy), 32'd0);
    tick;
    rst = 1'b0;
    at_neg;
    chk("t5_post_ready", 32'(rdy), 32'd1);
    chk("t5_post_ren", 32'(ren), 32'd0);
    tick;

    // T6 counter wrap on the 4-bit instance
    for (int k = 1; k <= 17; k++) begin
      drive(1, 0, 1, 0, 32'h0, 0);
      at_neg;
      if (k == 16)
        chk("t6_w_cnt15", 32'(w_cnt), 32'd15);
      if (k == 17) begin
        chk("t6_w_wrap", 32'(w_cnt), 32'd0);
        chk("t6_cnt16", 32'(cnt), 32'd16);
      end
      tick;
      drive(0, 0, 1, 1, 32'h100 + 32'(k), 0);
      tick;
      drive(0, 0, 1, 0, 32'h0, 1);
      tick;
    end
    drive(0, 0, 1, 0, 32'h0, 0);
    at_neg;
    chk("t6_final_cnt", 32'(cnt), 32'd17);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
